// File: rtl/fwd_hazard_unit_pkg.sv
// fwd_pkg: shared types and helpers for the forwarding/hazard unit.
//   fwd_state_e : memory-wait FSM states
//   FWD_RF      : fwd_sel code meaning "take operand from register file"
//   fwd_sel_w() : width of one fwd_sel field for a given stage count
package fwd_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } fwd_state_e;

    localparam int FWD_RF = 0;

    // Codes 0..NUM_STG must fit, so NUM_STG+1 distinct values.
    function automatic int fwd_sel_w(input int num_stg);
        return $clog2(num_stg + 1);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// fwd_hazard_unit_if: bundle of pipeline-side signals seen by the
// forwarding/hazard unit.
//   master : pipeline side (drives operands, producers, memory handshake)
//   slave  : the hazard unit (drives fwd_sel, stall/bubble/freeze, status)
interface fwd_hazard_unit_if #(
    parameter int AW      = 5,
    parameter int NUM_SRC = 2,
    parameter int NUM_STG = 2,
    parameter int CNT_W   = 16
);
    import fwd_pkg::*;

    localparam int SW = fwd_sel_w(NUM_STG);

    logic [NUM_SRC*AW-1:0] ex_rs;
    logic [NUM_SRC-1:0]    ex_src_used;
    logic [NUM_SRC*AW-1:0] id_rs;
    logic [NUM_SRC-1:0]    id_src_used;
    logic                  ex_memread;
    logic [AW-1:0]         ex_rd;
    logic [NUM_STG-1:0]    stg_regwrite;
    logic [NUM_STG*AW-1:0] stg_rd;
    logic                  mem_req;
    logic                  mem_ready;

    logic [NUM_SRC*SW-1:0] fwd_sel;
    logic                  stall_if_id;
    logic                  bubble_ex;
    logic                  freeze_all;
    logic                  mem_err;
    logic [CNT_W-1:0]      stall_cycles;

    modport master (
        output ex_rs, ex_src_used, id_rs, id_src_used, ex_memread, ex_rd,
               stg_regwrite, stg_rd, mem_req, mem_ready,
        input  fwd_sel, stall_if_id, bubble_ex, freeze_all, mem_err,
               stall_cycles
    );

    modport slave (
        input  ex_rs, ex_src_used, id_rs, id_src_used, ex_memread, ex_rd,
               stg_regwrite, stg_rd, mem_req, mem_ready,
        output fwd_sel, stall_if_id, bubble_ex, freeze_all, mem_err,
               stall_cycles
    );

endinterface

// File: rtl/fwd_hazard_unit_match.sv
// fwd_match: priority comparator for one operand source.
//   rs, used  : source register address and its valid
//   regwrite  : per-stage write enable
//   rd        : per-stage destination registers, stage k at rd[k*AW +: AW]
//   sel       : 0 = register file, k+1 = forward from stage k
// The youngest (lowest index) matching stage wins; register 0 never forwards.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int AW      = 5,
    parameter int NUM_STG = 2,
    parameter int SW      = fwd_sel_w(NUM_STG)
) (
    input  logic [AW-1:0]         rs,
    input  logic                  used,
    input  logic [NUM_STG-1:0]    regwrite,
    input  logic [NUM_STG*AW-1:0] rd,
    output logic [SW-1:0]         sel
);

    // Scan oldest to youngest so the youngest match overwrites the rest.
    always_comb begin
        sel = SW'(FWD_RF);
        for (int k = NUM_STG - 1; k >= 0; k--) begin
            if (used && regwrite[k] && (rd[k*AW +: AW] != '0) &&
                (rd[k*AW +: AW] == rs))
                sel = SW'(k + 1);
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding, load-use detection and memory-wait
// freeze for the pipelined core.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fwd_hazard_unit_if.slave
//     in : ex_rs/ex_src_used, id_rs/id_src_used, ex_memread, ex_rd,
//          stg_regwrite, stg_rd, mem_req, mem_ready
//     out: fwd_sel (per source), stall_if_id, bubble_ex, freeze_all,
//          mem_err (sticky timeout), stall_cycles (saturating)
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int AW          = 5,
    parameter int NUM_SRC     = 2,
    parameter int NUM_STG     = 2,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    fwd_hazard_unit_if.slave  bus
);

    localparam int SW = fwd_sel_w(NUM_STG);
    localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

    // ---------------- forwarding ----------------
    logic [NUM_SRC-1:0][SW-1:0] sel_raw;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        fwd_match #(
            .AW      (AW),
            .NUM_STG (NUM_STG),
            .SW      (SW)
        ) u_match (
            .rs       (bus.ex_rs[s*AW +: AW]),
            .used     (bus.ex_src_used[s]),
            .regwrite (bus.stg_regwrite),
            .rd       (bus.stg_rd),
            .sel      (sel_raw[s])
        );
    end

    // Outputs are forced quiet while reset is held, whatever the inputs.
    assign bus.fwd_sel = rst_n ? sel_raw : '0;

    // ---------------- load-use ----------------
    logic load_use;

    always_comb begin
        load_use = 1'b0;
        if (bus.ex_memread && (bus.ex_rd != '0)) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (bus.id_src_used[s] && (bus.id_rs[s*AW +: AW] == bus.ex_rd))
                    load_use = 1'b1;
            end
        end
    end

    // ---------------- memory-wait FSM ----------------
    fwd_state_e    state, state_nxt;
    logic [WW-1:0] wait_cnt, wait_nxt;
    logic          freeze, err_set, stall;

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        freeze    = 1'b0;
        err_set   = 1'b0;
        case (state)
            RUN: begin
                // A request completing in the same cycle needs no freeze.
                if (bus.mem_req && !bus.mem_ready) begin
                    freeze    = 1'b1;
                    wait_nxt  = '0;
                    state_nxt = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                // mem_req is ignored here; ready beats the timeout.
                if (bus.mem_ready) begin
                    state_nxt = RUN;
                end else begin
                    freeze = 1'b1;
                    if (wait_cnt == WAIT_LAST) begin
                        err_set   = 1'b1;
                        state_nxt = RUN;
                    end else begin
                        wait_nxt = wait_cnt + WW'(1);
                    end
                end
            end
            default: state_nxt = RUN;
        endcase
        if (!rst_n)
            freeze = 1'b0;
    end

    // A freeze already holds every register, so the bubble is not needed.
    assign stall           = rst_n && load_use && !freeze;
    assign bus.stall_if_id = stall;
    assign bus.bubble_ex   = stall;
    assign bus.freeze_all  = freeze;

    logic [CNT_W-1:0] stall_cnt;
    logic             err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            wait_cnt  <= '0;
            err_q     <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (err_set)
                err_q <= 1'b1;
            if ((stall || freeze) && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign bus.mem_err      = err_q;
    assign bus.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed cases followed by random
// stimulus, all compared against a cycle-numbered behavioural model.
module tb_fwd_hazard_unit;
    import fwd_pkg::*;

    localparam int AW  = 5;
    localparam int NS  = 2;
    localparam int NG  = 2;
    localparam int TO  = 8;
    localparam int CW  = 4;
    localparam int SW  = fwd_sel_w(NG);
    localparam int SAT = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.AW(AW), .NUM_SRC(NS), .NUM_STG(NG), .CNT_W(CW)) bus ();

    fwd_hazard_unit #(
        .AW(AW), .NUM_SRC(NS), .NUM_STG(NG), .MEM_TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_chk = 0;
    int n_err = 0;
    int nfz   = 0;

    // model state: request start cycle, sticky error, counter
    int cyc = 0;
    bit m_busy;
    int m_t0;
    bit m_err;
    int m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int fld(input logic [NS*AW-1:0] v, input int i);
        return int'(v[i*AW +: AW]);
    endfunction

    function automatic int exp_sel(input int s);
        if (!rst_n || !bus.ex_src_used[s]) return 0;
        for (int k = 0; k < NG; k++) begin
            if (bus.stg_regwrite[k] && fld(bus.stg_rd, k) != 0 &&
                fld(bus.stg_rd, k) == fld(bus.ex_rs, s))
                return k + 1;
        end
        return 0;
    endfunction

    function automatic bit exp_freeze();
        if (!rst_n) return 1'b0;
        if (m_busy) return !bus.mem_ready;
        return bus.mem_req && !bus.mem_ready;
    endfunction

    function automatic bit exp_stall();
        bit hit = 1'b0;
        if (!rst_n || exp_freeze()) return 1'b0;
        if (!bus.ex_memread || bus.ex_rd == '0) return 1'b0;
        for (int s = 0; s < NS; s++)
            if (bus.id_src_used[s] && fld(bus.id_rs, s) == int'(bus.ex_rd)) hit = 1'b1;
        return hit;
    endfunction

    task automatic check_now();
        for (int s = 0; s < NS; s++)
            chk($sformatf("fwd_sel%0d", s), 32'(bus.fwd_sel[s*SW +: SW]), 32'(exp_sel(s)));
        chk("stall_if_id", 32'(bus.stall_if_id), 32'(exp_stall()));
        chk("bubble_ex", 32'(bus.bubble_ex), 32'(exp_stall()));
        chk("freeze_all", 32'(bus.freeze_all), 32'(exp_freeze()));
        chk("mem_err", 32'(bus.mem_err), 32'(m_err));
        chk("stall_cycles", 32'(bus.stall_cycles), 32'(m_cnt));
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_err  = 1'b0;
        m_cnt  = 0;
    endtask

    // Advance the model across one rising edge using the inputs of that cycle.
    task automatic model_update();
        bit f = exp_freeze();
        bit st = exp_stall();
        if ((f || st) && m_cnt < SAT) m_cnt++;
        if (m_busy) begin
            if (bus.mem_ready) m_busy = 1'b0;
            else if (cyc - m_t0 == TO) begin
                m_busy = 1'b0;
                m_err  = 1'b1;
            end
        end else if (bus.mem_req && !bus.mem_ready) begin
            m_busy = 1'b1;
            m_t0   = cyc;
        end
        cyc++;
    endtask

    // Called 1ns after a rising edge with inputs already applied.
    task automatic step();
        @(negedge clk);
        check_now();
        if (bus.freeze_all) nfz++;
        @(posedge clk);
        if (rst_n) model_update();
        #1;
    endtask

    task automatic idle();
        bus.ex_rs = '0; bus.ex_src_used = '0; bus.id_rs = '0; bus.id_src_used = '0;
        bus.ex_memread = 1'b0; bus.ex_rd = '0; bus.stg_regwrite = '0; bus.stg_rd = '0;
        bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_now();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        model_reset();
        #1;
        check_now();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // forwarding priority
        bus.ex_src_used = 2'b11; bus.ex_rs = {5'd0, 5'd5};
        bus.stg_regwrite = 2'b11; bus.stg_rd = {5'd5, 5'd5};
        #1 chk("prio_young", 32'(bus.fwd_sel[SW-1:0]), 32'd1);
        step();
        bus.stg_regwrite = 2'b10;
        #1 chk("prio_old", 32'(bus.fwd_sel[SW-1:0]), 32'd2);
        step();

        // register 0 and unused source
        bus.stg_regwrite = 2'b11; bus.stg_rd = '0; bus.ex_rs = '0;
        #1 chk("rd_zero", 32'(bus.fwd_sel), 32'd0);
        step();
        bus.stg_rd = {5'd9, 5'd9}; bus.ex_rs = {5'd9, 5'd0}; bus.ex_src_used = 2'b01;
        #1 chk("src_unused", 32'(bus.fwd_sel[2*SW-1:SW]), 32'd0);
        step();

        // load-use
        idle();
        bus.ex_memread = 1'b1; bus.ex_rd = 5'd7; bus.id_rs = {5'd7, 5'd0}; bus.id_src_used = 2'b10;
        #1 chk("lu_stall", 32'(bus.stall_if_id), 32'd1);
        step();
        idle();
        chk("lu_cnt", 32'(bus.stall_cycles), 32'd1);
        step();
        bus.ex_memread = 1'b1; bus.ex_rd = 5'd7; bus.id_rs = {5'd7, 5'd0}; bus.id_src_used = 2'b01;
        #1 chk("lu_unused", 32'(bus.stall_if_id), 32'd0);
        step();

        // memory wait with ready at t0+3
        idle();
        do_reset();
        nfz = 0;
        bus.mem_req = 1'b1; step();
        bus.mem_req = 1'b0; step(); step();
        bus.mem_ready = 1'b1; step();
        bus.mem_ready = 1'b0; step();
        chk("wait_len", 32'(nfz), 32'd3);
        chk("wait_cnt", 32'(bus.stall_cycles), 32'd3);
        chk("wait_err", 32'(bus.mem_err), 32'd0);

        // timeout
        do_reset();
        nfz = 0;
        bus.mem_req = 1'b1; step();
        bus.mem_req = 1'b0;
        repeat (11) step();
        chk("to_len", 32'(nfz), 32'(TO + 1));
        chk("to_err", 32'(bus.mem_err), 32'd1);
        bus.mem_req = 1'b1; bus.mem_ready = 1'b1;
        #1 chk("to_nofreeze", 32'(bus.freeze_all), 32'd0);
        step();
        idle(); step();
        chk("err_sticky", 32'(bus.mem_err), 32'd1);

        // reset in the second MEM_WAIT cycle
        do_reset();
        bus.mem_req = 1'b1; step();
        bus.mem_req = 1'b0; step();
        chk("pre_rst_freeze", 32'(bus.freeze_all), 32'd1);
        bus.stg_regwrite = 2'b01; bus.stg_rd = {5'd0, 5'd3};
        bus.ex_rs = {5'd3, 5'd3}; bus.ex_src_used = 2'b11;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_freeze", 32'(bus.freeze_all), 32'd0);
        chk("rst_cnt", 32'(bus.stall_cycles), 32'd0);
        chk("rst_fwd", 32'(bus.fwd_sel), 32'd0);
        bus.mem_ready = 1'b1;
        step(); step();
        rst_n = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        step(); step();

        // saturation
        idle();
        do_reset();
        bus.ex_memread = 1'b1; bus.ex_rd = 5'd4; bus.id_rs = {5'd0, 5'd4}; bus.id_src_used = 2'b01;
        repeat (20) step();
        chk("sat", 32'(bus.stall_cycles), 32'(SAT));

        // random
        idle();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            for (int i = 0; i < NS; i++) begin
                bus.ex_rs[i*AW +: AW] = AW'($urandom_range(0, 3));
                bus.id_rs[i*AW +: AW] = AW'($urandom_range(0, 3));
            end
            for (int k = 0; k < NG; k++)
                bus.stg_rd[k*AW +: AW] = AW'($urandom_range(0, 3));
            bus.ex_src_used  = NS'($urandom);
            bus.id_src_used  = NS'($urandom);
            bus.stg_regwrite = NG'($urandom);
            bus.ex_memread   = ($urandom_range(0, 2) == 0);
            bus.ex_rd        = AW'($urandom_range(0, 3));
            bus.mem_req      = ($urandom_range(0, 7) == 0);
            bus.mem_ready    = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard controller for the pipelined core, sitting beside the ID/EX and EX/MEM registers. It generalises two-source, two-stage forwarding to `NUM_SRC` operand ports and `NUM_STG` producer stages, and adds three things. It detects load-use hazards, freezes the pipeline during multi-cycle memory accesses with a timeout, and keeps a saturating stall-cycle counter.

## Interface
Parameters:
- `AW`, 5 — register address width
- `NUM_SRC`, 2 — operand read ports per instruction
- `NUM_STG`, 2 — forwarding producer stages; index 0 is youngest (EX/MEM), `NUM_STG-1` is oldest (MEM/WB)
- `MEM_TIMEOUT`, 16 — maximum wait cycles before a memory access is abandoned; must be ≥ 1
- `CNT_W`, 16 — stall counter width
- Derived: `SW = $clog2(NUM_STG+1)`

Ports:
- `clk`  in  1  — the single clock. Reset is asynchronous and active-low.
- `rst_n`  in  1  — active-low asynchronous reset
- `ex_rs`  in  `NUM_SRC*AW`  — source registers of the instruction in EX
- `ex_src_used`  in  `NUM_SRC`  — per-source valid for the EX instruction
- `id_rs`  in  `NUM_SRC*AW`  — source registers of the instruction in ID
- `id_src_used`  in  `NUM_SRC`  — per-source valid for the ID instruction
- `ex_memread`  in  1  — the EX instruction is a load
- `ex_rd`  in  `AW`  — destination register of the EX instruction
- `stg_regwrite`  in  `NUM_STG`  — per-stage register-write enable
- `stg_rd`  in  `NUM_STG*AW`  — per-stage destination register
- `mem_req`  in  1  — one-cycle pulse when MEM issues an access
- `mem_ready`  in  1  — one-cycle pulse when the access completes; may coincide with `mem_req`
- `fwd_sel`  out  `NUM_SRC*SW`  — per-source operand select. 0 = register file; k = stage k-1.
- `stall_if_id`  out  1  — hold PC and the IF/ID register
- `bubble_ex`  out  1  — load a NOP into ID/EX
- `freeze_all`  out  1  — hold every pipeline register
- `mem_err`  out  1  — sticky timeout flag
- `stall_cycles`  out  `CNT_W`  — saturating count of stall and freeze cycles

## Operation
- **Forward match.** Source s matches stage k when all of the following hold:
  - `ex_src_used[s]` is set
  - `stg_regwrite[k]` is set
  - `stg_rd[k]` is non-zero
  - `stg_rd[k] == ex_rs[s]`
- **Forward select.** `fwd_sel[s]` is k+1 for the lowest-index (youngest) matching k, otherwise 0. Register 0 never forwards.
- **Load-use hazard.** Asserted when `ex_memread` is set, `ex_rd` is non-zero, and `ex_rd` equals `id_rs[s]` for some s with `id_src_used[s]` set.
  - Effect: `stall_if_id = bubble_ex = 1`.
  - Suppressed while `freeze_all` is 1.
- **FSM states** (enum in the package):
  - `RUN`:
    - if `mem_req` and not `mem_ready`: `freeze_all = 1`, clear the wait counter, go to `MEM_WAIT`
    - if `mem_req` and `mem_ready` together: no freeze
  - `MEM_WAIT`:
    - `freeze_all = 1`; the wait counter increments each cycle
    - on `mem_ready`: `freeze_all = 0` in that cycle, go to `RUN`
    - else if the wait counter equals `MEM_TIMEOUT-1`: `freeze_all = 1` in that cycle, set `mem_err`, go to `RUN`
    - `mem_req` is ignored in this state
- **Stall counter.** `stall_cycles` increments by 1 in every cycle where `stall_if_id` or `freeze_all` is high, and saturates at all-ones.
- **`mem_err`.** Stays set until reset.

## Timing
- **Reset values.** The following hold while `rst_n` is low and take effect asynchronously:
  - state = `RUN`
  - wait counter = 0
  - `mem_err = 0`
  - `stall_cycles = 0`
  - `freeze_all = 0`, `stall_if_id = 0`, `bubble_ex = 0`
  - `fwd_sel` = all 0, regardless of inputs
- **Combinational outputs.** `fwd_sel`, `stall_if_id` and `bubble_ex` are combinational from the current inputs, with zero latency.
- **`freeze_all`.** Combinational from the state and `mem_req`/`mem_ready`.
- **Registered values.** State, wait counter, `mem_err` and `stall_cycles` update on the rising edge of `clk`.
- **Load-use bubble.** Lasts exactly one cycle. After the load advances to EX/MEM, the dependent source forwards from stage 0, or from the register file once the load retires.
- **Freeze length.** For a request at cycle t0 with ready at t0+n (n ≥ 1), `freeze_all` is high for cycles t0 through t0+n-1, i.e. n cycles.
- **Timeout length.** With no ready, the freeze lasts `1+MEM_TIMEOUT` cycles.
- **Reset mid-`MEM_WAIT`.** `freeze_all` drops immediately and a late `mem_ready` is ignored.

## Structure
- Package `fwd_pkg` holds:
  - state enum `{RUN, MEM_WAIT}`
  - constant `FWD_RF = 0`
  - a function computing `SW`
- Sub-module `fwd_match` is instantiated `NUM_SRC` times in a generate loop. Each instance is a priority comparator from one source address to a `fwd_sel` code across `NUM_STG` stages.
- The FSM, wait counter and stall counter live in the top module.

## Test plan
1. **Forward priority** (`NUM_STG=2`).
   - Stage 0 and stage 1 both write rd=5, `ex_rs[0]=5` → `fwd_sel[0]=1`.
   - Clear `stg_regwrite[0]` → `fwd_sel[0]=2`.
2. **Register 0 and unused sources.**
   - All stages write rd=0, `ex_rs=0` → `fwd_sel=0`.
   - rd=9 matches `ex_rs[1]=9` but `ex_src_used[1]=0` → `fwd_sel[1]=0`.
3. **Load-use.**
   - `ex_memread=1`, `ex_rd=7`, `id_rs[1]=7` used → `stall_if_id=bubble_ex=1` for one cycle, `stall_cycles` 0→1.
   - Same case with `id_src_used[1]=0` → no stall.
4. **Memory wait.** `mem_req` at t0, `mem_ready` at t0+3 → `freeze_all` high at t0, t0+1, t0+2; low at t0+3; `stall_cycles=3`; `mem_err=0`.
5. **Timeout.** `MEM_TIMEOUT=8`, no ready → `freeze_all` high for 9 cycles, then `mem_err=1` and the FSM is back in `RUN`. A new `mem_req`+`mem_ready` pulse then causes no freeze, and `mem_err` stays 1.
6. **Reset and saturation.**
   - Assert `rst_n=0` in the second `MEM_WAIT` cycle → `freeze_all=0` before the next edge, counters 0.
   - `CNT_W=4` with 20 stall cycles → `stall_cycles` holds at 15.
